servo_ramp_ctrl: RTL

SERVO_RAMP_CTRL -- requirements
Module: servo_ramp_ctrl

---
 rtl/servo_ramp_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/servo_ramp_ctrl.sv
// Servo position ramp controller: accepts a target angle, slews the PWM
// high time toward it by at most STEP per servo frame, then holds it for
// SETTLE_FRAMES frames before reporting completion.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | holding position, ready for a new command
// ST_LOAD   | one cycle: clamp the captured angle and compute the target
// ST_MOVE   | stepping dc_out toward the target on each frame tick
// ST_SETTLE | at target, counting frame ticks before pulsing done
module servo_ramp_ctrl #(
    parameter int unsigned CLK_HZ        = 50_000_000,
    parameter int unsigned FRAME_HZ      = 50,
    parameter int unsigned MIN_DC        = 50_000,
    parameter int unsigned MAX_DC        = 100_000,
    parameter int unsigned CTR_DC        = 75_000,
    parameter int unsigned STEP          = 2_778,
    parameter int unsigned DC_PER_DEG    = 278,
    parameter int unsigned SETTLE_FRAMES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_angle,
    input  logic        stop,
    output logic [31:0] dc_out,
    output logic        frame_tick,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic        err
);

    localparam logic [31:0] FRAME_LEN  = 32'(CLK_HZ / FRAME_HZ);
    localparam logic [31:0] FRAME_LAST = FRAME_LEN - 32'd1;
    localparam logic [31:0] MIN_DC_W   = 32'(MIN_DC);
    localparam logic [31:0] MAX_DC_W   = 32'(MAX_DC);
    localparam logic [31:0] CTR_DC_W   = 32'(CTR_DC);
    localparam logic [31:0] STEP_W     = 32'(STEP);
    localparam logic [31:0] PER_DEG_W  = 32'(DC_PER_DEG);
    localparam logic [31:0] SETTLE_W   = 32'(SETTLE_FRAMES);
    localparam logic [7:0]  MAX_ANGLE  = 8'd180;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_MOVE   = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_frame_cnt;
    logic [31:0] r_dc;
    logic [31:0] r_target;
    logic [31:0] r_settle_cnt;
    logic [7:0]  r_angle;
    logic        r_done;
    logic        r_aborted;

    logic        w_frame_tick;
    logic [7:0]  w_angle_clamp;
    logic [31:0] w_target_raw;
    logic [31:0] w_target_clamp;
    logic [31:0] w_diff;
    logic [31:0] w_dc_nxt;
    logic [31:0] w_target_nxt;
    logic [31:0] w_settle_nxt;
    logic [7:0]  w_angle_nxt;
    logic        w_done_nxt;
    logic        w_aborted_nxt;

    assign w_frame_tick   = (r_frame_cnt == FRAME_LAST);
    assign w_angle_clamp  = (r_angle > MAX_ANGLE) ? MAX_ANGLE : r_angle;
    assign w_target_raw   = MIN_DC_W + ({24'd0, w_angle_clamp} * PER_DEG_W);
    assign w_target_clamp = (w_target_raw < MIN_DC_W) ? MIN_DC_W :
                            (w_target_raw > MAX_DC_W) ? MAX_DC_W : w_target_raw;
    // Magnitude computed with the larger operand first so a downward move never wraps.
    assign w_diff         = (r_target >= r_dc) ? (r_target - r_dc) : (r_dc - r_target);

    assign cmd_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign err        = (r_state == ST_LOAD) && (r_angle > MAX_ANGLE);
    assign frame_tick = w_frame_tick;
    assign dc_out     = r_dc;
    assign done       = r_done;
    assign aborted    = r_aborted;

    // Free-running frame counter; wraps at FRAME_LEN-1 regardless of FSM state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_frame_cnt <= 32'd0;
        end else if (w_frame_tick) begin
            r_frame_cnt <= 32'd0;
        end else begin
            r_frame_cnt <= r_frame_cnt + 32'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath updates; stop takes priority over a coincident frame tick.
    always_comb begin
        w_state_nxt   = r_state;
        w_dc_nxt      = r_dc;
        w_target_nxt  = r_target;
        w_settle_nxt  = r_settle_cnt;
        w_angle_nxt   = r_angle;
        w_done_nxt    = 1'b0;
        w_aborted_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_angle_nxt = cmd_angle;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (stop) begin
                    w_aborted_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_target_nxt = w_target_clamp;
                    w_settle_nxt = 32'd0;
                    w_state_nxt  = ST_MOVE;
                end
            end
            ST_MOVE: begin
                if (stop) begin
                    w_aborted_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else if (w_frame_tick) begin
                    if (w_diff <= STEP_W) begin
                        w_dc_nxt     = r_target;
                        w_settle_nxt = 32'd0;
                        w_state_nxt  = ST_SETTLE;
                    end else if (r_target > r_dc) begin
                        w_dc_nxt = r_dc + STEP_W;
                    end else begin
                        w_dc_nxt = r_dc - STEP_W;
                    end
                end
            end
            ST_SETTLE: begin
                if (stop) begin
                    w_aborted_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else if (w_frame_tick) begin
                    if ((r_settle_cnt + 32'd1) >= SETTLE_W) begin
                        w_done_nxt   = 1'b1;
                        w_settle_nxt = 32'd0;
                        w_state_nxt  = ST_IDLE;
                    end else begin
                        w_settle_nxt = r_settle_cnt + 32'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath registers; reset recentres the servo and drops any pending target.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dc         <= CTR_DC_W;
            r_target     <= CTR_DC_W;
            r_settle_cnt <= 32'd0;
            r_angle      <= 8'd0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_dc         <= w_dc_nxt;
            r_target     <= w_target_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_angle      <= w_angle_nxt;
            r_done       <= w_done_nxt;
            r_aborted    <= w_aborted_nxt;
        end
    end

endmodule
